// File: rtl/reg_pkg.sv
// Shared defaults, sizing helper and occupancy type for the register pipeline.
package reg_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;
   localparam int unsigned DEFAULT_DEPTH = 3;
   localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VALUE = '0;

   // Ceiling log2, usable in constant expressions; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      int unsigned span;
      result = 0;
      span   = 1;
      while ((span < value) && (result < 32)) begin
         span   = span << 1;
         result = result + 1;
      end
      return result;
   endfunction

   typedef logic [clog2(DEFAULT_DEPTH + 1) - 1:0] occ_t;

endpackage

// File: rtl/reg_pipe_stage.sv
// One valid+data register stage; data only loads on a real beat so bubbles never toggle it.
module reg_pipe_stage
   import reg_pkg::*;
#(
   parameter int unsigned          WIDTH       = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             adv,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   // Flush only drops valid; the data register keeps its last contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= RESET_VALUE;
      end else begin
         if (clear) begin
            valid <= 1'b0;
         end else if (adv) begin
            valid <= up_valid;
         end
         if (adv && up_valid && !clear) begin
            data <= up_data;
         end
      end
   end

endmodule

// File: rtl/reg_pipeline.sv
// DEPTH-stage retiming pipeline with valid/ready back-pressure, bubble collapse,
// synchronous flush and a registered occupancy count.
module reg_pipeline
   import reg_pkg::*;
#(
   parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
   parameter int unsigned      DEPTH       = DEFAULT_DEPTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [clog2(DEPTH + 1)-1:0]  occupancy
);

   localparam int unsigned CNT_W = clog2(DEPTH + 1);

   if (DEPTH == 0) begin : g_bad_depth
      $error("reg_pipeline: DEPTH must be at least 1");
   end

   logic [DEPTH:0]   adv;
   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] up_valid;
   logic [WIDTH-1:0] data    [DEPTH];
   logic [WIDTH-1:0] up_data [DEPTH];
   logic             in_acc;
   logic             out_acc;

   assign adv[DEPTH] = out_ready;
   assign in_ready   = adv[0] & ~clear;
   assign in_acc     = in_valid & in_ready;
   assign out_valid  = valid[DEPTH-1];
   assign out_data   = data[DEPTH-1];
   assign out_acc    = out_valid & out_ready;

   for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
      // A stage may move when any stage at or after it is empty, or the sink is ready.
      assign adv[i] = out_ready | ~(&valid[DEPTH-1:i]);

      if (i == 0) begin : g_head
         assign up_valid[i] = in_acc;
         assign up_data[i]  = in_data;
      end else begin : g_body
         assign up_valid[i] = valid[i-1];
         assign up_data[i]  = data[i-1];
      end

      reg_pipe_stage #(
         .WIDTH       (WIDTH),
         .RESET_VALUE (RESET_VALUE)
      ) u_stage (
         .clk      (clk),
         .reset    (reset),
         .clear    (clear),
         .adv      (adv[i]),
         .up_valid (up_valid[i]),
         .up_data  (up_data[i]),
         .valid    (valid[i]),
         .data     (data[i])
      );
   end

   // Net beats in minus beats out; an output drained during a flush is not double counted.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         occupancy <= '0;
      end else begin
         occupancy <= occupancy + CNT_W'(in_acc) - CNT_W'(out_acc);
      end
   end

endmodule
